// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score datapath:
//   - FSM state type for the increment pulse generator
//   - default parameter values for score_incr_gen
//   - 7-segment digit patterns shared with the score digit counters
// No ports (package).
// ---------------------------------------------------------------------------
package score_pkg;

    // Increment generator states: wait for work, emit pulse, enforce spacing.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StGap   = 2'd2
    } incr_state_e;

    // Default generator parameters.
    localparam int unsigned DefGap        = 2;
    localparam int unsigned DefPendW      = 4;
    localparam int unsigned DefSyncStages = 2;

    // 7-segment patterns, active-high, bit order {g, f, e, d, c, b, a}.
    localparam logic [6:0] Seg0     = 7'b0111111;
    localparam logic [6:0] Seg1     = 7'b0000110;
    localparam logic [6:0] Seg2     = 7'b1011011;
    localparam logic [6:0] Seg3     = 7'b1001111;
    localparam logic [6:0] Seg4     = 7'b1100110;
    localparam logic [6:0] Seg5     = 7'b1101101;
    localparam logic [6:0] Seg6     = 7'b1111101;
    localparam logic [6:0] Seg7     = 7'b0000111;
    localparam logic [6:0] Seg8     = 7'b1111111;
    localparam logic [6:0] Seg9     = 7'b1101111;
    localparam logic [6:0] SegBlank = 7'b0000000;

    // Decimal digit to segment pattern; non-decimal codes show blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SegBlank;
        case (digit)
            4'd0:    seg = Seg0;
            4'd1:    seg = Seg1;
            4'd2:    seg = Seg2;
            4'd3:    seg = Seg3;
            4'd4:    seg = Seg4;
            4'd5:    seg = Seg5;
            4'd6:    seg = Seg6;
            4'd7:    seg = Seg7;
            4'd8:    seg = Seg8;
            4'd9:    seg = Seg9;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Synchronizes an asynchronous level into the clk_i domain and emits a
// one-cycle pulse for every rising edge of the synchronized level.
//
// Ports:
//   clk_i    in   system clock
//   rst_ni   in   asynchronous active-low reset
//   async_i  in   raw asynchronous level
//   rise_o   out  one-cycle pulse per rising edge of the synchronized level
//
// The edge history resets to 1 so a level already high when reset releases
// is not taken as an edge. While the synchronizer still holds reset zeros
// (first SyncStages cycles) the history is pinned at 1; otherwise those
// zeros would look like a real low and a held-high input would be counted.
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic [SyncStages-1:0] fill_q, fill_d;
    logic                  hist_q, hist_d;
    logic                  synced;
    logic                  primed;

    assign synced = sync_q[SyncStages-1];
    // Top fill bit set once the last sync stage holds a real sample.
    assign primed = fill_q[SyncStages-1];

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], async_i};
        fill_d = {fill_q[SyncStages-2:0], 1'b1};
        hist_d = primed ? synced : 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            fill_q <= '0;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            fill_q <= fill_d;
            hist_q <= hist_d;
        end
    end

    assign rise_o = primed & synced & ~hist_q;

endmodule

// File: rtl/score_incr_gen.sv
// ---------------------------------------------------------------------------
// score_incr_gen
// Turns raw asynchronous scoring levels into clean one-cycle increment
// pulses for the ones-digit score counter. Rising edges are synchronized,
// queued in a saturating pending counter, and released with at least Gap
// idle cycles between pulses (pulse period Gap+2 under backlog).
//
// Ports:
//   clk_i       in   system clock, all logic on posedge
//   rst_ni      in   asynchronous active-low reset
//   event_i     in   raw asynchronous level; each rising edge is one point
//   enable_i    in   1 = game running, new pulses may start
//   clear_i     in   drops the queue, clears overflow, returns FSM to idle
//   incr_o      out  registered one-cycle increment pulse
//   pending_o   out  registered count of queued, not-yet-issued points
//   overflow_o  out  sticky; a point was dropped at saturation
// ---------------------------------------------------------------------------
module score_incr_gen
    import score_pkg::*;
#(
    parameter int unsigned Gap        = DefGap,
    parameter int unsigned PendW      = DefPendW,
    parameter int unsigned SyncStages = DefSyncStages
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             event_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             incr_o,
    output logic [PendW-1:0] pending_o,
    output logic             overflow_o
);

    localparam int unsigned   GapW    = (Gap > 1) ? $clog2(Gap + 1) : 1;
    localparam logic [PendW-1:0] PendMax = '1;

    incr_state_e       state_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              incr_q;
    logic [PendW-1:0]  pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              ev;
    logic              issue;

    // ------------------------------------------------------------------
    // Input synchronization and rising-edge detection
    // ------------------------------------------------------------------
    sync_edge #(
        .SyncStages (SyncStages)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (event_i),
        .rise_o  (ev)
    );

    // A pulse starts on the edge that leaves idle, so the pending decrement
    // lands on the same edge that raises incr_o.
    assign issue = (state_q == StIdle) && enable_i && (pend_q != '0) && !clear_i;

    // ------------------------------------------------------------------
    // Pending counter and sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            // Clear wins; a coincident event is intentionally lost.
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (ev && !issue) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (issue && !ev) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse FSM with gap counter and registered pulse output
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            incr_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            incr_q    <= 1'b0;
        end else begin
            incr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // enable_i only gates this transition; pulses and gaps
                    // already under way always complete.
                    if (issue) begin
                        state_q <= StPulse;
                        incr_q  <= 1'b1;
                    end
                end
                StPulse: begin
                    if (Gap > 0) begin
                        state_q   <= StGap;
                        gap_cnt_q <= GapW'(Gap);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt_q <= GapW'(1)) begin
                        state_q   <= StIdle;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    gap_cnt_q <= '0;
                end
            endcase
        end
    end

    assign incr_o     = incr_q;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_score_incr_gen.sv
// Bench for score_incr_gen: two instances (Gap=2 and Gap=0) share stimulus and
// are compared every cycle against a timestamp-based reference model.
module tb_score_incr_gen;

    localparam int unsigned PendW   = 4;
    localparam int          PendMax = (1 << PendW) - 1;
    localparam int          NDut    = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             event_i = 1'b0;
    logic             enable_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             incr_v [NDut];
    logic [PendW-1:0] pend_v [NDut];
    logic             ovf_v  [NDut];

    always #5 clk_i = ~clk_i;

    score_incr_gen #(
        .Gap        (2),
        .PendW      (PendW),
        .SyncStages (2)
    ) u_dut_gap2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .event_i    (event_i),
        .enable_i   (enable_i),
        .clear_i    (clear_i),
        .incr_o     (incr_v[0]),
        .pending_o  (pend_v[0]),
        .overflow_o (ovf_v[0])
    );

    score_incr_gen #(
        .Gap        (0),
        .PendW      (PendW),
        .SyncStages (2)
    ) u_dut_gap0 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .event_i    (event_i),
        .enable_i   (enable_i),
        .clear_i    (clear_i),
        .incr_o     (incr_v[1]),
        .pending_o  (pend_v[1]),
        .overflow_o (ovf_v[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: points credited from sampled input history, pulses
    // allowed when the last pulse is at least gap+2 edges in the past.
    int gaps   [NDut] = '{2, 0};
    int m_pend [NDut];
    int m_ovf  [NDut];
    int m_last [NDut];
    int m_pulse[NDut];
    bit samp[$];
    int t = 0;

    task automatic model_reset();
        samp.delete();
        for (int i = 0; i < NDut; i++) begin
            m_pend[i]  = 0;
            m_ovf[i]   = 0;
            m_last[i]  = -1000;
            m_pulse[i] = 0;
        end
    endtask

    task automatic model_edge();
        int n;
        bit ev;
        bit issue;
        samp.push_back(event_i);
        if (samp.size() > 8) void'(samp.pop_front());
        n  = samp.size();
        // A high sample after a low one is credited two edges later.
        ev = (n >= 4) && samp[n-3] && !samp[n-4];
        for (int i = 0; i < NDut; i++) begin
            issue = !clear_i && enable_i && (m_pend[i] > 0) && (t >= m_last[i] + gaps[i] + 2);
            if (clear_i) begin
                m_pend[i]  = 0;
                m_ovf[i]   = 0;
                m_last[i]  = -1000;
                m_pulse[i] = 0;
            end else begin
                m_pulse[i] = issue;
                if (issue) m_last[i] = t;
                if (ev && !issue) begin
                    if (m_pend[i] == PendMax) m_ovf[i] = 1;
                    else m_pend[i]++;
                end else if (issue && !ev) begin
                    m_pend[i]--;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        t++;
        model_edge();
        #1;
        for (int i = 0; i < NDut; i++) begin
            check_eq($sformatf("incr[%0d]@%0d", i, t), 32'(incr_v[i]), 32'(m_pulse[i]));
            check_eq($sformatf("pend[%0d]@%0d", i, t), 32'(pend_v[i]), 32'(m_pend[i]));
            check_eq($sformatf("ovf[%0d]@%0d", i, t), 32'(ovf_v[i]), 32'(m_ovf[i]));
        end
    endtask

    // Asserts reset mid-cycle and checks outputs drop before any clock edge.
    task automatic apply_reset(input int cycles);
        #2;
        rst_ni = 1'b0;
        #1;
        for (int i = 0; i < NDut; i++) begin
            check_eq($sformatf("rst_incr[%0d]", i), 32'(incr_v[i]), 0);
            check_eq($sformatf("rst_pend[%0d]", i), 32'(pend_v[i]), 0);
            check_eq($sformatf("rst_ovf[%0d]", i), 32'(ovf_v[i]), 0);
        end
        model_reset();
        repeat (cycles) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic queue_events(input int n);
        repeat (n) begin
            event_i = 1'b1;
            step();
            step();
            event_i = 1'b0;
            step();
            step();
        end
    endtask

    int cnt;
    int last;
    int hold;

    initial begin
        // Input high across reset release must not count.
        event_i  = 1'b1;
        enable_i = 1'b1;
        apply_reset(3);
        repeat (10) step();
        check_eq("held_high_pend", 32'(pend_v[0]), 0);
        event_i = 1'b0;
        repeat (3) step();
        event_i = 1'b1;
        step();
        step();
        step();
        check_eq("first_pend_k2", 32'(pend_v[0]), 1);
        check_eq("first_incr_k2", 32'(incr_v[0]), 0);
        step();
        check_eq("first_incr_k3", 32'(incr_v[0]), 1);
        event_i = 1'b0;
        repeat (6) step();

        // Backlog of 5 with enable low, then drain at Gap+2 spacing.
        enable_i = 1'b0;
        queue_events(5);
        step();
        check_eq("backlog5_pend", 32'(pend_v[0]), 5);
        enable_i = 1'b1;
        cnt  = 0;
        last = -1;
        repeat (30) begin
            step();
            if (incr_v[0]) begin
                if (last >= 0) check_eq("drain_spacing", 32'(t - last), 4);
                last = t;
                cnt++;
            end
        end
        check_eq("drain_count", 32'(cnt), 5);
        check_eq("drain_end_pend", 32'(pend_v[0]), 0);

        // Gap=0 instance: backlog of 3 drains on alternate cycles.
        enable_i = 1'b0;
        queue_events(3);
        step();
        enable_i = 1'b1;
        cnt  = 0;
        last = -1;
        repeat (12) begin
            step();
            if (incr_v[1]) begin
                if (last >= 0) check_eq("gap0_spacing", 32'(t - last), 2);
                last = t;
                cnt++;
            end
        end
        check_eq("gap0_count", 32'(cnt), 3);

        // Saturation and overflow, then clear.
        enable_i = 1'b0;
        queue_events(17);
        step();
        check_eq("sat_pend", 32'(pend_v[0]), 15);
        check_eq("sat_ovf", 32'(ovf_v[0]), 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_eq("clr_pend", 32'(pend_v[0]), 0);
        check_eq("clr_ovf", 32'(ovf_v[0]), 0);
        enable_i = 1'b1;
        repeat (5) step();

        // Event credited on the same edge as a pulse with one queued point.
        enable_i = 1'b0;
        queue_events(1);
        step();
        event_i = 1'b1;
        step();
        step();
        enable_i = 1'b1;
        step();
        check_eq("coinc_incr", 32'(incr_v[0]), 1);
        check_eq("coinc_pend", 32'(pend_v[0]), 1);
        event_i = 1'b0;
        repeat (3) step();
        step();
        check_eq("coinc_next_pulse", 32'(incr_v[0]), 1);
        repeat (6) step();

        // Reset in the middle of a gap with 3 points still queued.
        enable_i = 1'b0;
        queue_events(4);
        step();
        enable_i = 1'b1;
        step();
        step();
        check_eq("pre_rst_pend", 32'(pend_v[0]), 3);
        event_i = 1'b1;
        apply_reset(2);
        repeat (10) step();
        event_i = 1'b0;
        repeat (4) step();

        // Randomized traffic with enable toggling and occasional clears.
        hold = 2;
        repeat (600) begin
            if (hold == 0) begin
                event_i = ~event_i;
                hold    = $urandom_range(6, 2);
            end
            hold--;
            if ($urandom_range(15, 0) == 0) enable_i = ~enable_i;
            clear_i = ($urandom_range(59, 0) == 0);
            step();
        end
        clear_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_incr_gen.md
# score_incr_gen

Generates the single-cycle increment pulses consumed by the score digit counters' increment input. Raw scoring events (pipe passed, debug key) arrive asynchronously as levels. They are synchronized and edge-detected, then queued in a saturating pending counter. They are released as clean one-cycle pulses separated by a programmable gap, so the digit chain never sees merged or back-to-back increments. The block sits between game logic and the ones-digit counter, whose carry feeds the tens digit.

## Interface
- GAP, 2, idle cycles forced between consecutive output pulses (0 allowed)
- PEND_W, 4, width of pending-event counter; max queued = 2^PEND_W-1
- SYNC_STAGES, 2, synchronizer flop count (>=2)

- clk  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-low; one clock domain
- event_in  input  1  raw asynchronous scoring level; each rising edge = one point
- enable  input  1  synchronous; 1 = game running, pulses may issue
- clear  input  1  synchronous; drops queue, clears overflow, returns FSM to IDLE
- incr_out  output  1  registered one-cycle increment pulse to digit counter
- pending  output  PEND_W  registered count of queued, not-yet-issued points
- overflow  output  1  sticky; an event was dropped because pending was saturated

## Operation
- Reset (reset=0): sync flops 0, edge-history flop 1, pending 0, overflow 0, incr_out 0, FSM IDLE, gap counter 0. Effect is immediate, independent of clk.
- Edge history resets to 1, so event_in already high at reset release is not counted.
- Event = synced level 1 and history 0, i.e. one per rising edge of event_in.
- Pending update per cycle:
  - event only: +1.
  - issue only (FSM in PULSE): -1.
  - both in same cycle: unchanged.
  - event at saturation with no issue: value held, overflow set to 1 (sticky).
- clear has priority over event, issue and enable:
  - pending cleared to 0, overflow cleared to 0, FSM forced to IDLE, incr_out 0 next cycle.
  - An event coincident with clear is lost.
- enable=0 blocks the IDLE->PULSE transition only. Events still queue. A PULSE or GAP already in progress completes.
- FSM states:
  - IDLE: goes to PULSE when enable=1 and pending!=0.
  - PULSE: incr_out=1, pending decrements. Goes to GAP if GAP>0, else to IDLE.
  - GAP: gap counter loads GAP on entry and counts down. Goes to IDLE when it reaches 1.
- With GAP=0 and continuous backlog, IDLE<->PULSE alternate, so the minimum pulse period is 2 cycles.

## Timing
- event_in sampled high at edge k (after being low): pending increments at edge k+SYNC_STAGES.
- incr_out goes high for the cycle starting at edge k+SYNC_STAGES+1, if IDLE, enabled and no clear.
- incr_out is exactly one cycle wide. It is driven from a register, never combinationally from inputs.
- Backlog drain: consecutive rising edges of incr_out are exactly GAP+2 cycles apart while enable=1.
- pending decrements on the same edge that asserts incr_out.
- Rising edges of event_in closer than 1 cycle apart after synchronization are not guaranteed distinct. Inputs must hold each level for at least 2 clk cycles.

## Structure
- Package score_pkg holds:
  - typedef enum of the FSM states {IDLE, PULSE, GAP}.
  - Default parameter constants.
  - The 7-segment digit constants already shared by the score counters.
- Sub-module sync_edge (SYNC_STAGES flops plus history flop, outputs a one-cycle rise pulse).
- Top module holds the pending counter, overflow flag, gap counter and FSM.

## Test plan
- Reset with event_in=1, release, hold high 10 cycles -> pending stays 0, no incr_out; then low->high -> pending 1, incr_out at edge k+3 (SYNC_STAGES=2).
- 5 events 4 cycles apart with enable=0, then enable=1 -> pending reaches 5, then 5 pulses spaced 4 cycles (GAP=2), pending ends 0.
- 17 events with enable=0, PEND_W=4 -> pending saturates at 15, overflow=1; then clear -> pending 0, overflow 0, no incr_out.
- Event detected in the same cycle as a PULSE, with pending=1 -> pending stays 1, next pulse follows the gap.
- Assert reset in mid-GAP with pending=3 -> all outputs 0 immediately (before next clk edge), no pulses after release until a new rising edge.
- GAP=0, backlog 3 -> pulses on alternate cycles, exactly 3 pulses.
